// File: rtl/squares_pkg.sv
// Shared direction codes for the squares game datapath.
package squares_pkg;
  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  typedef logic [1:0] dir_t;
endpackage

// File: rtl/onehot_to_dir.sv
// 4->2 priority encoder for button pulses; the highest set bit wins, so
// multi-hot input resolves the same way the upstream selector would.
module onehot_to_dir
  import squares_pkg::*;
(
  input  logic [3:0] onehot_i,
  output dir_t       dir_o
);
  always_comb begin
    dir_o = DIR_RIGHT;
    if (onehot_i[3])      dir_o = DIR_UP;
    else if (onehot_i[2]) dir_o = DIR_DOWN;
    else if (onehot_i[1]) dir_o = DIR_LEFT;
  end
endmodule

// File: rtl/dir_event_queue.sv
// FWFT queue of encoded button presses with registered head/valid outputs.
// Optional drop counter output ovf_count is enabled by DIR_QUEUE_OVF_CNT_EN.
module dir_event_queue
  import squares_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    evt_in,
  output logic [1:0]    out_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] level,
  output logic          overflow
`ifdef DIR_QUEUE_OVF_CNT_EN
  ,
  output logic [7:0]    ovf_count
`endif
);
  localparam int PW = $clog2(DEPTH);

  dir_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          out_valid_q, out_valid_d;
  dir_t          out_dir_q, out_dir_d;
  logic          ovf_q;
  dir_t          evt_code;
  logic          push, pop, full, push_ok, drop;

  onehot_to_dir u_enc (
    .onehot_i (evt_in),
    .dir_o    (evt_code)
  );

  always_comb begin
    full    = (level_q == LW'(DEPTH));
    push    = |evt_in;
    pop     = out_valid_q & out_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;

    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push_ok) level_d = level_q - LW'(1);

    out_valid_d = (level_d != '0);
    // The only slot written this cycle is wr_ptr_q; bypass it when it becomes the head.
    out_dir_d = DIR_RIGHT;
    if (out_valid_d) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) out_dir_d = evt_code;
      else                                   out_dir_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_dir_q   <= DIR_RIGHT;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_dir_q   <= out_dir_d;
      ovf_q       <= drop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= evt_code;
  end

`ifdef DIR_QUEUE_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                           ovf_cnt_q <= '0;
    else if (drop && ovf_cnt_q != '1)  ovf_cnt_q <= ovf_cnt_q + 8'd1;
  end

  assign ovf_count = ovf_cnt_q;
`endif

  assign out_dir   = out_dir_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
endmodule

// File: doc/dir_event_queue.md
Name: dir_event_queue

Overview:
Buffers single-cycle button-press events for the game logic. Its input is the one-hot 4-bit pulse that comes after the input synchronizer, the rising-edge detector and the priority one-hot selector. It encodes each press into a 2-bit direction code and holds the codes in a small FIFO, so no press is lost while the game FSM is busy. It presents the oldest code on a valid/ready interface.

Parameters:
DEPTH, 4, number of queued events; must be a power of two and at least 2
LW, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden)

Ports:
clk  in  1  system clock (the fast domain)
rst  in  1  reset; synchronous, active-high
evt_in  in  4  one-hot press pulse; 4'b0000 means no event this cycle
out_dir  out  2  direction code at the head of the queue
out_valid  out  1  queue non-empty; out_dir is meaningful
out_ready  in  1  consumer accepts the head this cycle
level  out  LW  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse when an event is dropped

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - read and write pointers = 0
  - level = 0, out_valid = 0, out_dir = 2'b00, overflow = 0
- Reset mid-operation discards all queued events. The evt_in present in the reset cycle is ignored.
- Push condition: |evt_in = 1.
- Encoding: bit3→3, bit2→2, bit1→1, bit0→0.
  - Multi-hot input is illegal upstream but defined here: the highest set bit wins, matching the upstream priority order.
- Pop condition: out_valid & out_ready. out_ready while out_valid = 0 has no effect.
- First-word-fall-through storage, registered outputs:
  - An event pushed in cycle N into an empty queue gives out_valid = 1 and out_dir = its code in cycle N+1.
  - There is no combinational path from evt_in to any output.
- out_dir is a registered copy of mem[rd_ptr] when non-empty. It reads 2'b00 while empty.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Full is level == DEPTH; empty is level == 0.
- Simultaneous events:
  - Push and pop in the same cycle, not full: both happen; level unchanged; the head advances.
  - Push and pop in the same cycle while full: the pop frees a slot, the push is accepted, and overflow stays 0.
  - Push while full with no pop: the event is dropped, storage is unchanged, and overflow = 1 for exactly the next cycle.
  - Push into empty with out_ready = 1: the pop is not possible that cycle, because out_valid is still 0.
- level updates +1 on push-only, -1 on pop-only, and stays the same on both or neither.
- The head never changes while out_valid = 1 and out_ready = 0.

Optional Feature:
- Macro: DIR_QUEUE_OVF_CNT_EN.
- When defined:
  - adds output port ovf_count[7:0];
  - ovf_count increments on every dropped event and saturates at 255;
  - ovf_count clears only on rst.
- When undefined: the port and counter do not exist. Everything else is identical.

Decomposition:
- Shared package squares_pkg holds:
  - localparams DIR_RIGHT=2'd0, DIR_LEFT=2'd1, DIR_DOWN=2'd2, DIR_UP=2'd3;
  - typedef dir_t (logic [1:0]).
- One sub-module, onehot_to_dir: a combinational 4→2 priority encoder with the highest bit winning. It is instantiated once on evt_in.
- The FIFO stays inline.

Test Plan:
- Reset, then evt_in=4'b0100 for 1 cycle with out_ready=0 → next cycle out_valid=1, out_dir=2, level=1; values hold for 10 cycles.
- Push 4'b0001, 4'b0010, 4'b1000 on consecutive cycles, then out_ready=1 → out_dir sequence 0, 1, 3, one code per cycle; out_valid falls after the third pop; level returns to 0.
- DEPTH=4: push 5 events with out_ready=0 → level=4, overflow pulses once after the 5th push, and the 5th code is absent on drain. With DIR_QUEUE_OVF_CNT_EN defined, ovf_count=1.
- Full queue, push 4'b0010 with out_ready=1 in the same cycle → overflow=0, level stays 4, and the last drained code is 1.
- evt_in=4'b0110 (multi-hot) → queued code is 2. Push 6 events, assert rst mid-stream → next cycle out_valid=0 and level=0, and no stale code appears afterward.
- DIR_QUEUE_OVF_CNT_EN defined: 300 drops while full → ovf_count=255.
